// File: rtl/cnn_ctrl_pkg.sv
//------------------------------------------------------------------------------
// cnn_ctrl_pkg
// Shared layer-sequencer constants, FSM state encoding and pipeline tag type.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cnn_ctrl_pkg;

  localparam int INPUT_NUM_MEM             = 8;
  localparam int IFMAP_PAR                 = 4;
  localparam int NUM_ONE_PIXEL_CYCLE_INTER = 9;
  localparam int OUT_FEATURE_WIDTH         = 8;
  localparam int NUM_ONEMULT               = 2;
  localparam int PIPE_LAT                  = 4;

  localparam int NUM_GRP    = INPUT_NUM_MEM / IFMAP_PAR;
  localparam int PIX_CYCLES = NUM_ONE_PIXEL_CYCLE_INTER * NUM_GRP;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  localparam int TAP_W   = $clog2(NUM_ONE_PIXEL_CYCLE_INTER);
  localparam int GRP_W   = clog2_min1(NUM_GRP);
  localparam int POS_W   = $clog2(OUT_FEATURE_WIDTH);
  localparam int OFM_W   = clog2_min1(NUM_ONEMULT);
  localparam int DRAIN_W = clog2_min1(PIPE_LAT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Issue-side attributes of one tap, carried alongside the RAM/MAC pipeline
  typedef struct packed {
    logic             first;
    logic             last;
    logic [GRP_W-1:0] grp;
    logic [POS_W-1:0] col;
    logic [POS_W-1:0] row;
    logic [OFM_W-1:0] ofm;
  } seq_tag_t;

endpackage

`default_nettype wire

// File: rtl/conv_seq_delay_line.sv
//------------------------------------------------------------------------------
// conv_seq_delay_line
// Fixed-depth tag shift register with a shared hold (enable) control.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module conv_seq_delay_line
  import cnn_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clock,
  input  logic     reset_n,
  input  logic     en,
  input  seq_tag_t din,
  output seq_tag_t dout
);

  seq_tag_t r_stage [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else if (en) begin
      r_stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign dout = r_stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/conv_tile_sequencer.sv
//------------------------------------------------------------------------------
// conv_tile_sequencer
// Walks taps/groups/pixels/maps for one conv pass and aligns MAC controls.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module conv_tile_sequencer
  import cnn_ctrl_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stall,
  output logic             busy,
  output logic             done,
  output logic             rden,
  output logic             addr_en,
  output logic [GRP_W-1:0] grp_sel,
  output logic [TAP_W-1:0] tap_idx,
  output logic             accum_sload,
  output logic             mult_en,
  output logic             pix_valid,
  output logic [POS_W-1:0] out_col,
  output logic [POS_W-1:0] out_row,
  output logic [OFM_W-1:0] ofm_idx
);

  seq_state_t         r_state;
  logic [TAP_W-1:0]   r_tap;
  logic [GRP_W-1:0]   r_grp;
  logic [POS_W-1:0]   r_col;
  logic [POS_W-1:0]   r_row;
  logic [OFM_W-1:0]   r_ofm;
  logic [DRAIN_W-1:0] r_drain;
  logic               r_busy;
  logic               r_done;
  logic               r_rden;
  logic               r_pix_valid;
  logic [POS_W-1:0]   r_out_col;
  logic [POS_W-1:0]   r_out_row;
  logic [OFM_W-1:0]   r_ofm_idx;

  logic     w_tap_last, w_grp_last, w_col_last, w_row_last, w_ofm_last, w_final;
  logic     w_pipe_en;
  seq_tag_t w_tag_in;
  seq_tag_t w_tag_out;

  assign w_tap_last = (r_tap == TAP_W'(NUM_ONE_PIXEL_CYCLE_INTER - 1));
  assign w_grp_last = (r_grp == GRP_W'(NUM_GRP - 1));
  assign w_col_last = (r_col == POS_W'(OUT_FEATURE_WIDTH - 1));
  assign w_row_last = (r_row == POS_W'(OUT_FEATURE_WIDTH - 1));
  assign w_ofm_last = (r_ofm == OFM_W'(NUM_ONEMULT - 1));
  assign w_final    = w_tap_last & w_grp_last & w_col_last & w_row_last & w_ofm_last;

  // Stall only freezes the active pass; IDLE/DONE keep flushing so done is never held
  assign w_pipe_en = ~(stall & ((r_state == RUN) | (r_state == DRAIN)));

  always_comb begin
    w_tag_in = '0;
    if (r_state == RUN) begin
      w_tag_in.first = (r_tap == '0) & (r_grp == '0);
      w_tag_in.last  = w_tap_last & w_grp_last;
      w_tag_in.grp   = r_grp;
      w_tag_in.col   = r_col;
      w_tag_in.row   = r_row;
      w_tag_in.ofm   = r_ofm;
    end
  end

  conv_seq_delay_line #(
    .DEPTH (PIPE_LAT)
  ) u_delay_line (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (w_pipe_en),
    .din     (w_tag_in),
    .dout    (w_tag_out)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_tap   <= '0;
      r_grp   <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_ofm   <= '0;
      r_drain <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rden  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_rden  <= 1'b1;
            r_tap   <= '0;
            r_grp   <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_ofm   <= '0;
          end
        end
        RUN: begin
          if (!stall) begin
            // Nested wrap/carry: tap -> grp -> col -> row -> ofm
            if (w_tap_last) begin
              r_tap <= '0;
              if (w_grp_last) begin
                r_grp <= '0;
                if (w_col_last) begin
                  r_col <= '0;
                  if (w_row_last) begin
                    r_row <= '0;
                    r_ofm <= w_ofm_last ? '0 : r_ofm + 1'b1;
                  end else begin
                    r_row <= r_row + 1'b1;
                  end
                end else begin
                  r_col <= r_col + 1'b1;
                end
              end else begin
                r_grp <= r_grp + 1'b1;
              end
            end else begin
              r_tap <= r_tap + 1'b1;
            end
            if (w_final) begin
              r_state <= DRAIN;
              r_rden  <= 1'b0;
              r_drain <= '0;
            end
          end
        end
        DRAIN: begin
          if (!stall) begin
            if (r_drain == DRAIN_W'(PIPE_LAT)) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_drain <= r_drain + 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pix_valid <= 1'b0;
      r_out_col   <= '0;
      r_out_row   <= '0;
      r_ofm_idx   <= '0;
    end else if (w_pipe_en) begin
      r_pix_valid <= w_tag_out.last;
      if (w_tag_out.last) begin
        r_out_col <= w_tag_out.col;
        r_out_row <= w_tag_out.row;
        r_ofm_idx <= w_tag_out.ofm;
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign rden        = r_rden & ~stall;
  assign addr_en     = r_rden & ~stall;
  assign mult_en     = r_busy & ~stall;
  assign tap_idx     = r_tap;
  assign grp_sel     = w_tag_out.grp;
  assign accum_sload = w_tag_out.first;
  assign pix_valid   = r_pix_valid;
  assign out_col     = r_out_col;
  assign out_row     = r_out_row;
  assign ofm_idx     = r_ofm_idx;

endmodule

`default_nettype wire

// File: tb/tb_conv_tile_sequencer.sv
//------------------------------------------------------------------------------
// tb_conv_tile_sequencer
// Directed passes (plain, stalled, boundary stall, spurious start, reset).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_conv_tile_sequencer;
  import cnn_ctrl_pkg::*;

  logic             clock   = 1'b0;
  logic             reset_n = 1'b0;
  logic             start   = 1'b0;
  logic             stall   = 1'b0;
  logic             busy, done, rden, addr_en, accum_sload, mult_en, pix_valid;
  logic [GRP_W-1:0] grp_sel;
  logic [TAP_W-1:0] tap_idx;
  logic [POS_W-1:0] out_col, out_row;
  logic [OFM_W-1:0] ofm_idx;

  conv_tile_sequencer dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .rden        (rden),
    .addr_en     (addr_en),
    .grp_sel     (grp_sel),
    .tap_idx     (tap_idx),
    .accum_sload (accum_sload),
    .mult_en     (mult_en),
    .pix_valid   (pix_valid),
    .out_col     (out_col),
    .out_row     (out_row),
    .ofm_idx     (ofm_idx)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Per-pass event record, indexed by cycle number (cycle 0 = first busy cycle)
  int rden_cnt, rden_first, rden_last, sload_cnt, sload_first, sload_off, grp_err;
  int pix_cnt, pix_first, pix_last, pix_first_pos, pix_last_pos;
  int done_cnt, done_cyc, busy_after1, busy_after2, stall_leak, tap_max;
  int tap_s100, tap_s109, tap_s111;
  logic [31:0] rst_vec;

  function automatic logic [31:0] out_vec();
    return 32'({busy, done, rden, addr_en, grp_sel, tap_idx, accum_sload,
                mult_en, pix_valid, out_col, out_row, ofm_idx});
  endfunction

  task automatic run_pass(input int st_lo, input int st_hi, input int sp_a,
                          input int sp_b, input int rst_at);
    rden_cnt = 0; rden_first = -1; rden_last = -1;
    sload_cnt = 0; sload_first = -1; sload_off = 0; grp_err = 0;
    pix_cnt = 0; pix_first = -1; pix_last = -1; pix_first_pos = -1; pix_last_pos = -1;
    done_cnt = 0; done_cyc = -1; busy_after1 = -1; busy_after2 = -1;
    stall_leak = 0; tap_max = 0; tap_s100 = -1; tap_s109 = -1; tap_s111 = -1;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    for (int t = 0; t < 2400; t++) begin
      stall = (t >= st_lo) && (t <= st_hi);
      start = (t == sp_a) || (t == sp_b);
      if (t == rst_at) begin
        #2 reset_n = 1'b0;
        #1 rst_vec = out_vec();
        break;
      end
      @(negedge clock);
      if (rden) begin
        rden_cnt++;
        if (rden_first < 0) rden_first = t;
        rden_last = t;
      end
      if (accum_sload) begin
        sload_cnt++;
        if (sload_first < 0) sload_first = t;
        if ((t - 4) % PIX_CYCLES != 0) sload_off++;
      end
      if (t >= 4 && t <= 21 && grp_sel !== GRP_W'(t >= 13)) grp_err++;
      if (pix_valid && !stall) begin
        pix_cnt++;
        if (pix_first < 0) begin
          pix_first = t;
          pix_first_pos = {out_col, out_row, ofm_idx};
        end
        pix_last = t;
        pix_last_pos = {out_col, out_row, ofm_idx};
      end
      if (done) begin
        done_cnt++;
        done_cyc = t;
      end
      if (done_cyc >= 0 && t == done_cyc + 1) busy_after1 = busy;
      if (done_cyc >= 0 && t == done_cyc + 2) busy_after2 = busy;
      if (stall && (rden || addr_en || mult_en)) stall_leak++;
      if (int'(tap_idx) > tap_max) tap_max = tap_idx;
      if (t == 100) tap_s100 = tap_idx;
      if (t == 109) tap_s109 = tap_idx;
      if (t == 111) tap_s111 = tap_idx;
      if (done_cyc >= 0 && t >= done_cyc + 2) break;
      @(posedge clock); #1;
    end
    stall = 1'b0;
    start = 1'b0;
  endtask

  // sh: shift of end-of-pass events; full: also check start-of-pass alignment
  task automatic check_pass(input string sc, input int sh, input bit full);
    chk_eq({sc, ".rden_cnt"},  rden_cnt, 2304);
    chk_eq({sc, ".rden_last"}, rden_last, 2303 + sh);
    chk_eq({sc, ".pix_cnt"},   pix_cnt, 128);
    chk_eq({sc, ".pix_last"},  pix_last, 2308 + sh);
    chk_eq({sc, ".last_pos"},  pix_last_pos, (7 << 4) | (7 << 1) | 1);
    chk_eq({sc, ".done_cyc"},  done_cyc, 2309 + sh);
    chk_eq({sc, ".done_cnt"},  done_cnt, 1);
    chk_eq({sc, ".busy_drop"}, busy_after1, 0);
    if (full) begin
      chk_eq({sc, ".rden_first"},  rden_first, 0);
      chk_eq({sc, ".sload_first"}, sload_first, 4);
      chk_eq({sc, ".sload_cnt"},   sload_cnt, 128);
      chk_eq({sc, ".sload_off"},   sload_off, 0);
      chk_eq({sc, ".grp_err"},     grp_err, 0);
      chk_eq({sc, ".pix_first"},   pix_first, 22);
      chk_eq({sc, ".first_pos"},   pix_first_pos, 0);
      chk_eq({sc, ".tap_max"},     tap_max, 8);
    end
  endtask

  initial begin
    #23 reset_n = 1'b1;
    @(negedge clock);
    chk_eq("reset.outputs", out_vec(), 0);

    run_pass(-1, -1, -1, -1, -1);
    check_pass("basic", 0, 1'b1);

    run_pass(100, 109, -1, -1, -1);
    check_pass("stall", 10, 1'b0);
    chk_eq("stall.leak",     stall_leak, 0);
    chk_eq("stall.tap_c100", tap_s100, 1);
    chk_eq("stall.tap_c109", tap_s109, 1);
    chk_eq("stall.tap_c111", tap_s111, 2);
    chk_eq("stall.pix_first", pix_first, 22);

    run_pass(2303, 2304, -1, -1, -1);
    check_pass("edge", 2, 1'b0);
    chk_eq("edge.leak", stall_leak, 0);

    run_pass(-1, -1, 50, 2309, -1);
    check_pass("spur", 0, 1'b1);
    chk_eq("spur.busy_idle", busy_after2, 0);

    run_pass(-1, -1, -1, -1, 1000);
    chk_eq("midrst.outputs", rst_vec, 0);
    @(negedge clock) reset_n = 1'b1;

    run_pass(-1, -1, -1, -1, -1);
    check_pass("after_rst", 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
